// File: rtl/trigger_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_sequencer_if
//  Purpose  : Control, configuration and status signals of the trigger
//             sequencer. The master side drives the controls and lengths.
//             The slave side (the sequencer) drives the status outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface trigger_sequencer_if #(
    parameter int CNT_W = 16
);
    // control / trigger sources
    logic             arm;
    logic             abort;
    logic             trig_in;
    logic             edge_pos;
    logic             sw_trig;
    logic             sample_valid;
    // acquisition configuration (latched at arm)
    logic [CNT_W-1:0] pretrig_len;
    logic [CNT_W-1:0] posttrig_len;
    logic [CNT_W-1:0] holdoff_len;
    // status
    logic             capture_en;
    logic             busy;
    logic             triggered;
    logic             done;
    logic             aborted;
    logic [2:0]       state;

    modport master (
        output arm, abort, trig_in, edge_pos, sw_trig, sample_valid,
        output pretrig_len, posttrig_len, holdoff_len,
        input  capture_en, busy, triggered, done, aborted, state
    );

    modport slave (
        input  arm, abort, trig_in, edge_pos, sw_trig, sample_valid,
        input  pretrig_len, posttrig_len, holdoff_len,
        output capture_en, busy, triggered, done, aborted, state
    );
endinterface
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_sequencer
//  Purpose  : Oscilloscope-style acquisition sequencer. An acquisition has
//             five states:
//                 IDLE -> PRETRIG -> ARMED -> POSTTRIG -> HOLDOFF -> IDLE
//             PRETRIG and POSTTRIG count sample strobes. ARMED waits for an
//             edge or a software trigger. HOLDOFF counts clock cycles.
//             All status outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module trigger_sequencer #(
    parameter int CNT_W = 16
) (
    input  wire                  clk,
    input  wire                  reset,
    trigger_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRETRIG  = 3'd1,
        S_ARMED    = 3'd2,
        S_POSTTRIG = 3'd3,
        S_HOLDOFF  = 3'd4
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] pre_q,        pre_d;
    logic [CNT_W-1:0] post_q,       post_d;
    logic [CNT_W-1:0] hold_q,       hold_d;
    logic             edge_pos_q,   edge_pos_d;
    logic             trig_d_q;
    logic             triggered_q,  triggered_d;
    logic             done_q,       done_d;
    logic             aborted_q,    aborted_d;
    logic             capture_en_q, capture_en_d;
    logic             busy_q,       busy_d;

    // The increment is one bit wider than the counter. A terminal count of
    // 2^CNT_W-1 is then compared exactly, and the counter never wraps.
    logic [CNT_W:0]   cnt_inc;
    logic             hit_pre;
    logic             hit_post;
    logic             hit_hold;
    logic             trig_edge;

    // Terminal-count compares against the latched lengths, and the edge detector
    assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit_pre   = (cnt_inc == {1'b0, pre_q});
    assign hit_post  = (cnt_inc == {1'b0, post_q});
    assign hit_hold  = (cnt_inc == {1'b0, hold_q});
    // trig_d_q runs in every state. So a level that is already present when
    // ARMED is entered produces no edge there; only a new transition does.
    assign trig_edge = edge_pos_q ? ( bus.trig_in & ~trig_d_q)
                                  : (~bus.trig_in &  trig_d_q);

    // Next-state, counter, configuration-latch and pulse decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        post_d      = post_q;
        hold_d      = hold_q;
        edge_pos_d  = edge_pos_q;
        triggered_d = 1'b0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        if ((state_q != S_IDLE) && bus.abort) begin
            // Abort wins over any trigger or completion in the same cycle
            state_d   = S_IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm) begin
                        pre_d      = bus.pretrig_len;
                        post_d     = bus.posttrig_len;
                        hold_d     = bus.holdoff_len;
                        edge_pos_d = bus.edge_pos;
                        cnt_d      = '0;
                        state_d    = (bus.pretrig_len == '0) ? S_ARMED : S_PRETRIG;
                    end
                end

                S_PRETRIG: begin
                    if (bus.sample_valid) begin
                        if (hit_pre) begin
                            state_d = S_ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc[CNT_W-1:0];
                        end
                    end
                end

                S_ARMED: begin
                    if (trig_edge || bus.sw_trig) begin
                        triggered_d = 1'b1;
                        cnt_d       = '0;
                        if (post_q != '0) begin
                            state_d = S_POSTTRIG;
                        end else if (hold_q != '0) begin
                            state_d = S_HOLDOFF;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end

                S_POSTTRIG: begin
                    if (bus.sample_valid) begin
                        if (hit_post) begin
                            cnt_d = '0;
                            if (hold_q != '0) begin
                                state_d = S_HOLDOFF;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                    end
                end

                S_HOLDOFF: begin
                    // Counting starts at 0 on entry. So exactly hold_q cycles
                    // are spent here before the return to IDLE.
                    if (hit_hold) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc[CNT_W-1:0];
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // These status flags are registered copies of the decoded next state.
        // They therefore always agree with state_q.
        capture_en_d = (state_d == S_PRETRIG) || (state_d == S_ARMED) ||
                       (state_d == S_POSTTRIG);
        busy_d       = (state_d != S_IDLE);
    end

    // State, counter, latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            hold_q       <= '0;
            edge_pos_q   <= 1'b0;
            trig_d_q     <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            capture_en_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            hold_q       <= hold_d;
            edge_pos_q   <= edge_pos_d;
            trig_d_q     <= bus.trig_in;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            capture_en_q <= capture_en_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.capture_en = capture_en_q;
    assign bus.busy       = busy_q;
    assign bus.triggered  = triggered_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;

endmodule
`default_nettype wire
